// File: rtl/fetch_block_pkg.sv
// Shared types for the fetch front end: word/half-word types, pipeline control
// signal types and the fetch FSM state encoding.
package fetch_block_pkg;

  typedef logic [31:0] WORD;
  typedef logic [15:0] HALF_WORD;
  typedef HALF_WORD    instruction;
  typedef logic        stall_pipeline_sig;
  typedef logic        flush_pipeline_sig;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_FLUSH
  } fetch_state_t;

  localparam WORD INSTR_BYTES = 32'd2;

  // Thumb fetch addresses are half-word aligned; bit 0 is never honoured.
  function automatic WORD align_half(input WORD addr);
    return {addr[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction and its PC, used to park the
// response that lands while decode is stalled.
module fetch_skid_buffer
  import fetch_block_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       capture,
  input  logic       release_entry,
  input  logic       clear,
  input  instruction capture_data,
  input  WORD        capture_pc,
  output logic       valid,
  output instruction data,
  output WORD        pc
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      data  <= capture_data;
      pc    <= capture_pc;
    end else if (release_entry) begin
      valid <= 1'b0;
    end
  end

  // A second capture without an intervening release would lose an instruction.
  skid_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(capture && valid && !release_entry && !clear));

endmodule

// File: rtl/fetch_block.sv
// Thumb fetch stage: PC generation, single-cycle-latency imem requests and the
// registered fetch/decode boundary with a one-entry skid for stalls.
//
// state   | meaning
// S_IDLE  | first cycle after reset, issue fetch at RESET_VECTOR
// S_RUN   | streaming one instruction per cycle
// S_HOLD  | decode stalled, outputs and skid frozen, no requests
// S_FLUSH | redirect issued last cycle, target response arriving
module fetch_block
  import fetch_block_pkg::*;
#(
  parameter WORD RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  stall_pipeline_sig stall_pipeline_i,
  input  flush_pipeline_sig flush_pipeline_i,
  input  WORD               branch_target_i,
  input  HALF_WORD          imem_data_i,
  output logic              imem_req_o,
  output WORD               imem_addr_o,
  output instruction        instruction_o,
  output WORD               program_counter_o,
  output logic              is_valid_o
);

  fetch_state_t state_q, state_d;
  WORD          pc_q;
  WORD          resp_pc_q;
  logic         inflight_q;

  logic         skid_valid;
  instruction   skid_data;
  WORD          skid_pc;
  logic         skid_capture, skid_release, skid_clear;
  logic         fd_load_mem, fd_load_skid, fd_kill;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = pc_q;
    skid_capture = 1'b0;
    skid_release = 1'b0;
    skid_clear   = 1'b0;
    fd_load_mem  = 1'b0;
    fd_load_skid = 1'b0;
    fd_kill      = 1'b0;
    if (!reset_i) begin
      imem_addr_o = flush_pipeline_i ? align_half(branch_target_i) : pc_q;
      if (flush_pipeline_i) begin
        // Redirect beats stall: whatever is in flight or parked is younger than the branch.
        imem_req_o = 1'b1;
        fd_kill    = 1'b1;
        skid_clear = 1'b1;
        state_d    = S_FLUSH;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            imem_req_o = 1'b1;
            state_d    = S_RUN;
          end
          S_RUN, S_HOLD, S_FLUSH: begin
            if (stall_pipeline_i) begin
              skid_capture = inflight_q;
              state_d      = S_HOLD;
            end else begin
              imem_req_o = 1'b1;
              if (skid_valid) begin
                fd_load_skid = 1'b1;
                skid_release = 1'b1;
              end else begin
                fd_load_mem = 1'b1;
              end
              state_d = S_RUN;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q       <= RESET_VECTOR;
      resp_pc_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        pc_q      <= imem_addr_o + INSTR_BYTES;
        resp_pc_q <= imem_addr_o;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instruction_o     <= '0;
      program_counter_o <= '0;
      is_valid_o        <= 1'b0;
    end else if (fd_kill) begin
      is_valid_o <= 1'b0;
    end else if (fd_load_skid) begin
      instruction_o     <= skid_data;
      program_counter_o <= skid_pc;
      is_valid_o        <= 1'b1;
    end else if (fd_load_mem) begin
      instruction_o     <= imem_data_i;
      program_counter_o <= resp_pc_q;
      is_valid_o        <= inflight_q;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .capture       (skid_capture),
    .release_entry (skid_release),
    .clear         (skid_clear),
    .capture_data  (imem_data_i),
    .capture_pc    (resp_pc_q),
    .valid         (skid_valid),
    .data          (skid_data),
    .pc            (skid_pc)
  );

endmodule

// File: tb/tb_fetch_block.sv
// Directed bench for fetch_block: streaming, stall/skid, flush, flush+stall,
// reset during hold and PC wrap with a high reset vector.
module tb_fetch_block;
  import fetch_block_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, stall, flush;
  WORD target;
  HALF_WORD imem_data;
  logic imem_req;
  WORD imem_addr;
  HALF_WORD instr;
  WORD pc;
  logic valid;

  logic reset_w;
  HALF_WORD imem_data_w;
  logic imem_req_w;
  WORD imem_addr_w;
  HALF_WORD instr_w;
  WORD pc_w;
  logic valid_w;

  int checks = 0;
  int errors = 0;

  fetch_block dut (
    .clk_i(clk), .reset_i(reset), .stall_pipeline_i(stall), .flush_pipeline_i(flush),
    .branch_target_i(target), .imem_data_i(imem_data), .imem_req_o(imem_req),
    .imem_addr_o(imem_addr), .instruction_o(instr), .program_counter_o(pc), .is_valid_o(valid)
  );

  fetch_block #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .reset_i(reset_w), .stall_pipeline_i(1'b0), .flush_pipeline_i(1'b0),
    .branch_target_i(32'h0), .imem_data_i(imem_data_w), .imem_req_o(imem_req_w),
    .imem_addr_o(imem_addr_w), .instruction_o(instr_w), .program_counter_o(pc_w), .is_valid_o(valid_w)
  );

  // Synchronous memory: data = 0x1000 + addr, one cycle after the request.
  always @(posedge clk) begin
    imem_data   <= imem_req   ? HALF_WORD'(16'h1000 + imem_addr[15:0])   : 16'hDEAD;
    imem_data_w <= imem_req_w ? HALF_WORD'(16'h1000 + imem_addr_w[15:0]) : 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; target = '0;
    tick(); tick();
    checks++;
    if ({valid, pc, instr} !== {1'b0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL reset_outputs: got %b %h %h required 0 00000000 0000", valid, pc, instr);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req: got %b required 0", imem_req);
    end
    checks++;
    if (dut.u_skid.valid !== 1'b0) begin
      errors++; $display("FAIL reset_skid: got %b required 0", dut.u_skid.valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL idle_request: got %b %h required 1 00000000", imem_req, imem_addr);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid: got %b required 0", valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, WORD'(2 * i)}) begin
        errors++; $display("FAIL stream_addr[%0d]: got %b %h required 1 %h", i, imem_req, imem_addr, 2 * i);
      end
      checks++;
      if (i < 2) begin
        if (valid !== 1'b0) begin
          errors++; $display("FAIL stream_bubble[%0d]: got %b required 0", i, valid);
        end
      end else if ({valid, pc, instr} !== {1'b1, WORD'(2 * (i - 2)), HALF_WORD'(16'h1000 + 2 * (i - 2))}) begin
        errors++; $display("FAIL stream_out[%0d]: got %b %h %h required 1 %h %h", i, valid, pc, instr,
                           2 * (i - 2), 16'h1000 + 2 * (i - 2));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_req_first: got %b required 0", imem_req);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({imem_req, valid, pc, instr} !== {1'b0, 1'b1, 32'h4, 16'h1004}) begin
        errors++; $display("FAIL stall_hold[%0d]: got %b %b %h %h required 0 1 00000004 1004", k, imem_req, valid, pc, instr);
      end
    end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if ({imem_req, imem_addr, valid, pc} !== {1'b1, 32'h8, 1'b1, 32'h4}) begin
      errors++; $display("FAIL stall_release: got %b %h %b %h required 1 00000008 1 00000004", imem_req, imem_addr, valid, pc);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({valid, pc, instr} !== {1'b1, WORD'(6 + 2 * k), HALF_WORD'(16'h1006 + 2 * k)}) begin
        errors++; $display("FAIL stall_resume[%0d]: got %b %h %h required 1 %h %h", k, valid, pc, instr, 6 + 2 * k, 16'h1006 + 2 * k);
      end
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; target = 32'h0000_0101;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL flush_addr: got %b %h required 1 00000100", imem_req, imem_addr);
    end
    tick();
    flush = 1'b0; target = '0;
    #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h102}) begin
      errors++; $display("FAIL flush_bubble: got %b %b %h required 0 1 00000102", valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({valid, pc, instr} !== {1'b1, 32'h100, 16'h1100}) begin
      errors++; $display("FAIL flush_target: got %b %h %h required 1 00000100 1100", valid, pc, instr);
    end
    tick();
    checks++;
    if ({valid, pc, instr} !== {1'b1, 32'h102, 16'h1102}) begin
      errors++; $display("FAIL flush_next: got %b %h %h required 1 00000102 1102", valid, pc, instr);
    end
  endtask

  task automatic test_flush_stall();
    stall = 1'b1;
    tick();
    checks++;
    if (dut.u_skid.valid !== 1'b1) begin
      errors++; $display("FAIL fs_skid_full: got %b required 1", dut.u_skid.valid);
    end
    flush = 1'b1; target = 32'h0000_0200;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
      errors++; $display("FAIL fs_redirect: got %b %h required 1 00000200", imem_req, imem_addr);
    end
    tick();
    flush = 1'b0; target = '0;
    #1;
    checks++;
    if ({valid, imem_req, dut.u_skid.valid} !== 3'b000) begin
      errors++; $display("FAIL fs_cleared: got valid=%b req=%b skid=%b required 000", valid, imem_req, dut.u_skid.valid);
    end
    tick();
    checks++;
    if ({valid, imem_req} !== 2'b00) begin
      errors++; $display("FAIL fs_stalled: got %b %b required 0 0", valid, imem_req);
    end
    tick();
    stall = 1'b0;
    #1;
    checks++;
    if ({valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h202}) begin
      errors++; $display("FAIL fs_release: got %b %b %h required 0 1 00000202", valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({valid, pc, instr} !== {1'b1, 32'h200, 16'h1200}) begin
      errors++; $display("FAIL fs_target: got %b %h %h required 1 00000200 1200", valid, pc, instr);
    end
    tick();
    checks++;
    if ({valid, pc, instr} !== {1'b1, 32'h202, 16'h1202}) begin
      errors++; $display("FAIL fs_next: got %b %h %h required 1 00000202 1202", valid, pc, instr);
    end
  endtask

  task automatic test_reset_in_hold();
    stall = 1'b1;
    tick();
    checks++;
    if ({dut.u_skid.valid, valid, pc} !== {1'b1, 1'b1, 32'h202}) begin
      errors++; $display("FAIL rh_hold: got skid=%b %b %h required 1 1 00000202", dut.u_skid.valid, valid, pc);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    #1;
    checks++;
    if ({valid, pc, instr, dut.u_skid.valid} !== {1'b0, 32'h0, 16'h0, 1'b0}) begin
      errors++; $display("FAIL rh_cleared: got %b %h %h skid=%b required 0 00000000 0000 0", valid, pc, instr, dut.u_skid.valid);
    end
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rh_refetch: got %b %h required 1 00000000", imem_req, imem_addr);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL rh_stale: got %b %h required valid 0", valid, pc);
    end
    tick();
    checks++;
    if ({valid, pc, instr} !== {1'b1, 32'h0, 16'h1000}) begin
      errors++; $display("FAIL rh_first: got %b %h %h required 1 00000000 1000", valid, pc, instr);
    end
  endtask

  task automatic test_wrap();
    WORD exp_pc[4];
    HALF_WORD exp_in[4];
    exp_pc = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
    exp_in = '{16'h0FFC, 16'h0FFE, 16'h1000, 16'h1002};
    checks++;
    if ({valid_w, imem_req_w} !== 2'b00) begin
      errors++; $display("FAIL wrap_reset: got %b %b required 0 0", valid_w, imem_req_w);
    end
    reset_w = 1'b0;
    #1;
    checks++;
    if ({imem_req_w, imem_addr_w} !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_first_addr: got %b %h required 1 fffffffc", imem_req_w, imem_addr_w);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i <= 3) begin
        checks++;
        if (imem_addr_w !== exp_pc[i]) begin
          errors++; $display("FAIL wrap_addr[%0d]: got %h required %h", i, imem_addr_w, exp_pc[i]);
        end
      end
      if (i >= 2) begin
        checks++;
        if ({valid_w, pc_w, instr_w} !== {1'b1, exp_pc[i-2], exp_in[i-2]}) begin
          errors++; $display("FAIL wrap_out[%0d]: got %b %h %h required 1 %h %h", i, valid_w, pc_w, instr_w, exp_pc[i-2], exp_in[i-2]);
        end
      end
    end
  endtask

  initial begin
    reset_w = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_stall();
    test_reset_in_hold();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
